// File: rtl/proc_pkg.sv
// Shared processor definitions: default datapath width and divider FSM state encoding.
package proc_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it does not go negative.
module div_step
    import proc_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             msb_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        trial   = {rem_in, msb_in};
        diff    = trial - {1'b0, divisor};
        // A clear borrow bit means the divisor fits into the partial remainder.
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/done handshake; one quotient bit per
// clock, results registered and held until the next accepted start.
module seq_divider
    import proc_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_acc_q;
    logic [WIDTH-1:0] q_acc_q;
    logic             zero_q;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_acc_q),
        .msb_in  (q_acc_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dvs_q       <= '0;
            rem_acc_q   <= '0;
            q_acc_q     <= '0;
            zero_q      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        dvs_q       <= divisor;
                        if (divisor == '0) begin
                            // Preload the defined divide-by-zero results and skip the run.
                            zero_q    <= 1'b1;
                            q_acc_q   <= '1;
                            rem_acc_q <= dividend;
                            state_q   <= S_FIN;
                        end else begin
                            zero_q    <= 1'b0;
                            q_acc_q   <= dividend;
                            rem_acc_q <= '0;
                            cnt_q     <= CW'(WIDTH);
                            state_q   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem_acc_q <= step_rem;
                    q_acc_q   <= {q_acc_q[WIDTH-2:0], step_bit};
                    cnt_q     <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    quotient    <= q_acc_q;
                    remainder   <= rem_acc_q;
                    div_by_zero <= zero_q;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: table vectors, handshake corner cases and random pairs,
// with results checked through a scoreboard queue.
module tb_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } sb_item_t;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    sb_item_t sb[$];
    int       n_vec  = 0;
    int       n_fail = 0;

    seq_divider #(
        .WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic sb_item_t model(input logic [7:0] a, input logic [7:0] b);
        sb_item_t it;
        it.dvd = a;
        it.dvs = b;
        if (b == 8'd0) begin
            it.q  = 8'hFF;
            it.r  = a;
            it.dz = 1'b1;
        end else begin
            it.q  = a / b;
            it.r  = a % b;
            it.dz = 1'b0;
        end
        return it;
    endfunction

    // Scoreboard: every done must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_done: got done with no request pending, expected none");
            end else begin
                sb_item_t it;
                it = sb.pop_front();
                chk($sformatf("quot %0d/%0d", it.dvd, it.dvs), quotient, it.q);
                chk($sformatf("rem %0d/%0d", it.dvd, it.dvs), remainder, it.r);
                chk($sformatf("dz %0d/%0d", it.dvd, it.dvs), div_by_zero, it.dz);
                if (!it.dz) begin
                    chk($sformatf("identity %0d/%0d", it.dvd, it.dvs),
                        int'(quotient) * int'(it.dvs) + int'(remainder), int'(it.dvd));
                end
            end
        end
    end

    // Issue one request at a negedge and wait for its done; operands are scrambled after issue.
    task automatic run_op(input sb_item_t it, input int budget, output int lat,
                          output int busy_cnt);
        start    = 1'b1;
        dividend = it.dvd;
        divisor  = it.dvs;
        sb.push_back(it);
        lat      = 0;
        busy_cnt = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start    = 1'b0;
                dividend = 8'($urandom);
                divisor  = 8'($urandom);
            end
            if (busy) busy_cnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL timeout %0d/%0d: got no done, expected done within %0d cycles",
                     it.dvd, it.dvs, budget);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_vec++;
            n_fail++;
            $display("FAIL timeout %s: got no done, expected done within %0d cycles", name, budget);
        end
    endtask

    initial begin
        vec_t       vec[7];
        sb_item_t   it;
        int         lat;
        int         bc;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] bb_a[3];
        logic [7:0] bb_b[3];
        logic [7:0] bb_q[3];
        logic [7:0] bb_r[3];

        vec[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 10};
        vec[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 10};
        vec[2] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 10};
        vec[3] = '{8'd3,   8'd200, 8'd0,   8'd3,  1'b0, 10};
        vec[4] = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 10};
        vec[5] = '{8'd42,  8'd0,   8'hFF,  8'd42, 1'b1, 2};
        vec[6] = '{8'd9,   8'd3,   8'd3,   8'd0,  1'b0, 10};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quot", quotient, 0);
        chk("reset_rem", remainder, 0);
        chk("reset_dz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            it = '{vec[k].dvd, vec[k].dvs, vec[k].q, vec[k].r, vec[k].dz};
            run_op(it, 20, lat, bc);
            chk($sformatf("vec%0d_latency", k), lat, vec[k].lat);
            chk($sformatf("vec%0d_busy_cycles", k), bc, vec[k].lat - 1);
            @(negedge clk);
            chk($sformatf("vec%0d_quot_hold", k), quotient, vec[k].q);
            chk($sformatf("vec%0d_dz_hold", k), div_by_zero, vec[k].dz);
        end

        // A start while a division runs must be dropped entirely.
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd9;
        sb.push_back('{8'd200, 8'd9, 8'd22, 8'd2, 1'b0});
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", 20);
        repeat (15) @(negedge clk);
        chk("busy_start_quot_hold", quotient, 22);
        chk("busy_start_rem_hold", remainder, 2);

        // Asynchronous reset in the middle of a run abandons it.
        start    = 1'b1;
        dividend = 8'd77;
        divisor  = 8'd4;
        sb.push_back('{8'd77, 8'd4, 8'd19, 8'd1, 1'b0});
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_busy", busy, 0);
        chk("midrun_reset_done", done, 0);
        chk("midrun_reset_quot", quotient, 0);
        chk("midrun_reset_rem", remainder, 0);
        chk("midrun_reset_dz", div_by_zero, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrun_reset_no_done_quot", quotient, 0);
        run_op('{8'd77, 8'd4, 8'd19, 8'd1, 1'b0}, 20, lat, bc);
        chk("after_reset_latency", lat, 10);

        // Start held high relaunches every WIDTH+2 cycles; other cycles carry junk operands.
        bb_a = '{8'd100, 8'd200, 8'd77};
        bb_b = '{8'd7, 8'd9, 8'd4};
        bb_q = '{8'd14, 8'd22, 8'd19};
        bb_r = '{8'd2, 8'd2, 8'd1};
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            if (i % 10 == 0) begin
                dividend = bb_a[i / 10];
                divisor  = bb_b[i / 10];
                sb.push_back('{bb_a[i / 10], bb_b[i / 10], bb_q[i / 10], bb_r[i / 10], 1'b0});
            end else begin
                dividend = 8'($urandom);
                divisor  = 8'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        wait_done("back_to_back_last", 20);
        repeat (3) @(negedge clk);
        chk("back_to_back_drained", sb.size(), 0);

        // Random pairs, issued back to back in each done cycle.
        for (int n = 0; n < 1000; n++) begin
            a = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 8'd0;
                1:       b = 8'($urandom_range(1, 3));
                default: b = 8'($urandom);
            endcase
            run_op(model(a, b), 20, lat, bc);
            chk($sformatf("rand%0d_latency %0d/%0d", n, a, b), lat, (b == 8'd0) ? 2 : 10);
        end

        repeat (15) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
